// File: rtl/drop_tick_scheduler.sv
// rtl/drop_tick_scheduler.sv - drop-tick scheduler with prescaler, level-derived period and ack handshake
//
// A prescaler divides clk into time units. A period counter then counts
// those units and raises a drop request (tick_req) each time a period expires.
// The request stays high until the game FSM acknowledges it. If a period
// expires while a request is still pending, the sticky missed flag is set.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-low reset
//   enable       1 = run, 0 = return to IDLE and clear counters
//   pause        1 = freeze counters and outputs
//   level[3:0]   game level, shortens the drop period
//   soft_drop    1 = use SOFT_PERIOD
//   tick_ack     game FSM consumed tick_req
//   clear_missed clears missed (a simultaneous overrun wins)
//   tick_req     drop request, held until acknowledged
//   unit_tick    one-cycle pulse per PRESCALE counting cycles
//   state[1:0]   IDLE=00, RUN=01, PAUSE=10, WAIT_ACK=11
//   missed       sticky overrun flag

module drop_tick_scheduler #(
    parameter int PRESCALE    = 1024,
    parameter int MAX_PERIOD  = 48,
    parameter int STEP        = 3,
    parameter int MIN_PERIOD  = 4,
    parameter int SOFT_PERIOD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pause,
    input  logic [3:0] level,
    input  logic       soft_drop,
    input  logic       tick_ack,
    input  logic       clear_missed,
    output logic       tick_req,
    output logic       unit_tick,
    output logic [1:0] state,
    output logic       missed
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        PAUSE    = 2'b10,
        WAIT_ACK = 2'b11
    } state_t;

    localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    state_t          st;
    state_t          saved_st;
    state_t          eff_st;
    logic [PSW-1:0]  presc;
    logic [15:0]     period_cnt;
    logic [15:0]     target;
    int              raw_period;
    logic            count_en;
    logic            expiry;
    logic            missed_set;

    assign state = st;

    // Signed 32-bit arithmetic so that high levels go negative and clamp
    // instead of wrapping around to a huge period.
    always_comb begin
        raw_period = MAX_PERIOD - int'(level) * STEP;
        if (soft_drop)
            target = 16'(SOFT_PERIOD);
        else if (raw_period < MIN_PERIOD)
            target = 16'(MIN_PERIOD);
        else
            target = 16'(raw_period);
    end

    // Counting happens in RUN/WAIT_ACK, and also on the cycle that leaves PAUSE.
    // This way a pause of N cycles delays the next tick by exactly N cycles.
    assign count_en  = enable && !pause && (st != IDLE);
    assign unit_tick = count_en && (presc == PS_LAST);
    // Using >= means that lowering the target below the running count expires on the next unit tick.
    assign expiry    = unit_tick && (period_cnt >= target - 16'd1);
    assign eff_st    = (st == PAUSE) ? saved_st : st;

    // An ack that lands on an expiry cycle is consumed by the new tick.
    // That case is not counted as an overrun.
    assign missed_set = expiry && (eff_st == WAIT_ACK) && !(tick_ack && st == WAIT_ACK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= IDLE;
            saved_st   <= RUN;
            tick_req   <= 1'b0;
            missed     <= 1'b0;
            presc      <= '0;
            period_cnt <= '0;
        end else begin
            if (missed_set)
                missed <= 1'b1;
            else if (clear_missed)
                missed <= 1'b0;

            if (!enable) begin
                st         <= IDLE;
                tick_req   <= 1'b0;
                presc      <= '0;
                period_cnt <= '0;
            end else if (st == IDLE) begin
                if (!pause)
                    st <= RUN;
            end else if (pause) begin
                if (st != PAUSE) begin
                    saved_st <= st;
                    st       <= PAUSE;
                end
            end else begin
                presc <= unit_tick ? '0 : presc + 1'b1;
                if (expiry)
                    period_cnt <= '0;
                else if (unit_tick)
                    period_cnt <= period_cnt + 16'd1;

                if (expiry) begin
                    tick_req <= 1'b1;
                    st       <= WAIT_ACK;
                end else if (st == WAIT_ACK && tick_ack) begin
                    tick_req <= 1'b0;
                    st       <= RUN;
                end else begin
                    st <= eff_st;
                end
            end
        end
    end

endmodule

// File: tb/tb_drop_tick_scheduler.sv
// tb/tb_drop_tick_scheduler.sv - scoreboard bench for drop_tick_scheduler

module tb_drop_tick_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] level = 4'd0;
    logic       soft_drop = 1'b0;
    logic       clear_missed = 1'b0;
    logic       man_ack = 1'b0;
    logic       auto_ack_q = 1'b0;
    logic       tick_ack;
    logic       tick_req;
    logic       unit_tick;
    logic [1:0] state;
    logic       missed;

    int  cyc = 0;
    int  s = 0;
    int  checks = 0;
    int  errors = 0;
    int  ack_dly = 0;
    bit  auto_ack_en = 0;
    bit  ut_chk = 0;
    bit  prev_req = 0;
    int  exp_q[$];

    assign tick_ack = man_ack | auto_ack_q;

    drop_tick_scheduler #(
        .PRESCALE(4), .MAX_PERIOD(8), .STEP(2), .MIN_PERIOD(2), .SOFT_PERIOD(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .pause(pause), .level(level),
        .soft_drop(soft_drop), .tick_ack(tick_ack), .clear_missed(clear_missed),
        .tick_req(tick_req), .unit_tick(unit_tick), .state(state), .missed(missed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Monitor: pops expected request times, generates auto-acks, checks unit_tick phase
    always @(negedge clk) begin
        auto_ack_q = 1'b0;
        if (ack_dly > 0) begin
            ack_dly--;
            if (ack_dly == 0) auto_ack_q = 1'b1;
        end
        if (rst && tick_req && !prev_req) begin
            if (exp_q.size() == 0) check("tick_extra", cyc, -1);
            else check("tick_time", cyc, exp_q.pop_front());
            if (auto_ack_en) ack_dly = 2;
        end
        prev_req = tick_req;
        if (ut_chk) check("unit_tick", int'(unit_tick), int'((cyc - s) % 4 == 3));
    end

    task automatic run_start(input logic [3:0] lv, input bit sd, input int period,
                             input int n, input bit aa);
        ut_chk = 0;
        enable = 1'b0;
        @(negedge clk); #1;
        level = lv;
        soft_drop = sd;
        auto_ack_en = aa;
        enable = 1'b1;
        s = cyc + 1;
        ut_chk = 1;
        for (int k = 1; k <= n; k++) exp_q.push_back(s + period * k);
    endtask

    task automatic run_end();
        ut_chk = 0;
        enable = 1'b0;
        auto_ack_en = 0;
        check("tick_missing", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        #3;
        check("rst_state", int'(state), 0);
        check("rst_req", int'(tick_req), 0);
        check("rst_missed", int'(missed), 0);
        check("rst_ut", int'(unit_tick), 0);
        @(negedge clk); #1 rst = 1'b1;

        // level 0: 8 units * 4 cycles = 32 cycles, ack 3 cycles after each request
        run_start(4'd0, 0, 32, 3, 1);
        wait_cyc(s + 96);
        check("l0_missed", int'(missed), 0);
        #1 run_end();

        // level 3 -> 2 units; level 15 clamps to 2 units; soft drop -> 1 unit
        run_start(4'd3, 0, 8, 4, 1);
        wait_cyc(s + 32); #1 run_end();
        run_start(4'd15, 0, 8, 4, 1);
        wait_cyc(s + 32); #1 run_end();
        run_start(4'd0, 1, 4, 4, 1);
        wait_cyc(s + 16); #1 run_end();

        // no ack: overrun one period after the first request
        run_start(4'd0, 0, 32, 1, 0);
        wait_cyc(s + 63);
        check("miss_before", int'(missed), 0);
        wait_cyc(s + 64);
        check("miss_set", int'(missed), 1);
        check("miss_req", int'(tick_req), 1);
        check("miss_state", int'(state), 3);
        #1 run_end();
        @(negedge clk);
        check("miss_kept", int'(missed), 1);
        check("idle_req", int'(tick_req), 0);
        check("idle_state", int'(state), 0);
        #1 clear_missed = 1'b1;
        @(negedge clk);
        check("miss_clr", int'(missed), 0);
        #1 clear_missed = 1'b0;

        // pause for 10 cycles mid-period delays the next request by 10
        run_start(4'd3, 0, 8, 0, 1);
        ut_chk = 0;
        exp_q.push_back(s + 8);
        exp_q.push_back(s + 16);
        exp_q.push_back(s + 34);
        exp_q.push_back(s + 42);
        wait_cyc(s + 19);
        #1 pause = 1'b1;
        wait_cyc(s + 20);
        check("pause_state_a", int'(state), 2);
        wait_cyc(s + 29);
        check("pause_state_b", int'(state), 2);
        #1 pause = 1'b0;
        wait_cyc(s + 30);
        check("resume_state", int'(state), 1);
        wait_cyc(s + 42); #1 run_end();

        // ack on the expiry cycle: request stays, no overrun
        run_start(4'd3, 0, 8, 1, 0);
        wait_cyc(s + 15);
        check("ackexp_pre", int'(state), 3);
        #1 man_ack = 1'b1;
        wait_cyc(s + 16);
        check("ackexp_req", int'(tick_req), 1);
        check("ackexp_missed", int'(missed), 0);
        check("ackexp_state", int'(state), 3);
        #1 man_ack = 1'b0;
        run_end();
        @(negedge clk);
        check("dis_state", int'(state), 0);
        check("dis_req", int'(tick_req), 0);

        // asynchronous reset in WAIT_ACK, between clock edges
        run_start(4'd3, 0, 8, 1, 0);
        wait_cyc(s + 10);
        check("arst_pre", int'(state), 3);
        ut_chk = 0;
        #2 rst = 1'b0;
        #1;
        check("arst_state", int'(state), 0);
        check("arst_req", int'(tick_req), 0);
        check("arst_ut", int'(unit_tick), 0);
        check("arst_missed", int'(missed), 0);
        enable = 1'b0;
        check("tick_missing", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
